// File: rtl/xc_malu_divrem_result.sv
// xc_malu_divrem_result
//   Control and result stage wrapped around the iterative divider. Holds a
//   div/divu/rem/remu request, keeps the divider running until it reports
//   done, applies the RISC-V sign and divide-by-zero corrections to the
//   unsigned quotient/remainder, and offers the selected value on a
//   valid/ready writeback port.
//
//   Optional build macro: XC_MALU_DIVREM_ZERO_BYPASS_EN
//     defined   - a zero divisor skips the divider (IDLE -> RESP directly)
//     undefined - every request goes through the divider
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request, divider idle
//   WAIT  | operands latched, div_valid high until div_done
//   RESP  | corrected result held in rsp_data, rsp_valid high
module xc_malu_divrem_result #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            req_signed,
    input  logic            req_rem,
    output logic            div_valid,
    output logic            div_signed,
    output logic [XLEN-1:0] div_rs1,
    output logic [XLEN-1:0] div_rs2,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rmdr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            signed_q;
    logic            rem_q;
    logic [XLEN-1:0] rsp_data_q;

    logic            ld_req;
    logic            ld_rsp;
    logic [XLEN-1:0] rsp_data_d;

    logic            div_zero;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rmdr_fix;
    logic [XLEN-1:0] result_fix;

    // Handshake and divider-facing outputs are decoded from the registered
    // state only, so div_valid drops in the cycle after div_done.
    assign req_ready  = (state_q == ST_IDLE);
    assign div_valid  = (state_q == ST_WAIT);
    assign rsp_valid  = (state_q == ST_RESP);
    assign div_signed = signed_q;
    assign div_rs1    = rs1_q;
    assign div_rs2    = rs2_q;
    assign rsp_data   = rsp_data_q;

    // Sign and zero-divisor correction of the divider's unsigned magnitudes.
    // The most-negative / -1 case falls out of the plain negate.
    always_comb begin
        div_zero   = (rs2_q == '0);
        neg_q      = signed_q & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) & ~div_zero;
        neg_r      = signed_q & rs1_q[XLEN-1] & ~div_zero;
        quot_fix   = div_zero ? '1    : (neg_q ? ('0 - div_quot) : div_quot);
        rmdr_fix   = div_zero ? rs1_q : (neg_r ? ('0 - div_rmdr) : div_rmdr);
        result_fix = rem_q ? rmdr_fix : quot_fix;
    end

    // Next-state decode; flush wins over accept, done and handshake.
    always_comb begin
        state_d    = state_q;
        ld_req     = 1'b0;
        ld_rsp     = 1'b0;
        rsp_data_d = result_fix;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ld_req = 1'b1;
`ifdef XC_MALU_DIVREM_ZERO_BYPASS_EN
                    if (req_rs2 == '0) begin
                        state_d    = ST_RESP;
                        ld_rsp     = 1'b1;
                        rsp_data_d = req_rem ? req_rs1 : '1;
                    end else begin
                        state_d = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                if (div_done) begin
                    ld_rsp  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            ld_req  = 1'b0;
            ld_rsp  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on accept and result capture on completion.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            signed_q   <= 1'b0;
            rem_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (ld_req) begin
                rs1_q    <= req_rs1;
                rs2_q    <= req_rs2;
                signed_q <= req_signed;
                rem_q    <= req_rem;
            end
            if (ld_rsp) begin
                rsp_data_q <= rsp_data_d;
            end
        end
    end

endmodule

// File: tb/tb_xc_malu_divrem_result.sv
// tb_xc_malu_divrem_result
//   Bench for xc_malu_divrem_result. Plays the iterative divider and the
//   writeback consumer, and compares against an arithmetic reference of
//   RISC-V div/divu/rem/remu. Honours XC_MALU_DIVREM_ZERO_BYPASS_EN.
module tb_xc_malu_divrem_result;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        req_signed;
    logic        req_rem;
    logic        div_valid;
    logic        div_signed;
    logic [31:0] div_rs1;
    logic [31:0] div_rs2;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rmdr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;
    int episodes = 0;
    logic        prev_dv = 1'b0;
    logic [31:0] exp_rs1 = '0;
    logic [31:0] exp_rs2 = '0;
    logic        exp_sgn = 1'b0;
    logic [31:0] exp_data = '0;

`ifdef XC_MALU_DIVREM_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    xc_malu_divrem_result dut (
        .clock      (clock),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_signed (req_signed),
        .req_rem    (req_rem),
        .div_valid  (div_valid),
        .div_signed (div_signed),
        .div_rs1    (div_rs1),
        .div_rs2    (div_rs2),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rmdr   (div_rmdr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension semantics via wide signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic s, input logic r);
        longint sa, sb, q, m;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (s && sa == -64'sd2147483648 && sb == -64'sd1) begin
            q = -64'sd2147483648;
            m = 0;
        end else begin
            q = sa / sb;
            m = sa % sb;
        end
        return r ? m[31:0] : q[31:0];
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Compare process: whenever an output is meaningful, check it.
    always @(negedge clock) begin
        if (div_valid && !prev_dv) episodes++;
        prev_dv = div_valid;
        if (resetn) begin
            if (rsp_valid) chk("mon_rsp_data", rsp_data, exp_data);
            if (div_valid) begin
                chk("mon_div_rs1", div_rs1, exp_rs1);
                chk("mon_div_rs2", div_rs2, exp_rs2);
                chk("mon_div_signed", {31'd0, div_signed}, {31'd0, exp_sgn});
            end
            if (div_valid && rsp_valid) chk("mon_exclusive", 32'd1, 32'd0);
        end
    end

    // Presents a request for one cycle (IDLE assumed) and records expectations.
    task automatic start_req(input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic r, input logic [31:0] exp);
        exp_rs1 = a; exp_rs2 = b; exp_sgn = s; exp_data = exp;
        req_rs1 = a; req_rs2 = b; req_signed = s; req_rem = r; req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        req_rs1 = $urandom; req_rs2 = $urandom;
        req_signed = 1'($urandom); req_rem = 1'($urandom);
    endtask

    // Divider model: unsigned magnitudes, garbage for a zero divisor.
    task automatic give_done(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? (32'd0 - a) : a;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        div_done = 1'b1;
        if (mb == 32'd0) begin
            div_quot = $urandom; div_rmdr = $urandom;
        end else begin
            div_quot = ma / mb; div_rmdr = ma % mb;
        end
        cyc();
        div_done = 1'b0;
        div_quot = $urandom; div_rmdr = $urandom;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic r, input logic [31:0] exp, input int lat, input int hold);
        int  ep0;
        bit  byp;
        ep0 = episodes;
        byp = BYPASS && (b == 32'd0);
        start_req(a, b, s, r, exp);
        if (!byp) begin
            for (int i = 0; i < lat; i++) begin
                chk("div_valid_held", {31'd0, div_valid}, 32'd1);
                chk("no_early_rsp", {31'd0, rsp_valid}, 32'd0);
                cyc();
            end
            chk("div_valid_wait", {31'd0, div_valid}, 32'd1);
            give_done(a, b, s);
        end
        chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
        chk("div_valid_off", {31'd0, div_valid}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk("rsp_data_hold", rsp_data, exp);
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            div_done = 1'($urandom);
            cyc();
            div_done = 1'b0;
        end
        chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_data", rsp_data, exp);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("no_accept_handshake", {31'd0, div_valid}, 32'd0);
        chk("div_episodes", episodes - ep0, byp ? 32'd0 : 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic        s, r;
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
        req_signed = 1'b0; req_rem = 1'b0; div_done = 1'b0; div_quot = '0;
        div_rmdr = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_div_valid", {31'd0, div_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_div_rs1", div_rs1, 32'd0);
        chk("rst_div_rs2", div_rs2, 32'd0);
        chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();

        // Pin the reference model with hand-computed values.
        chk("model_divu", ref_result(32'd100, 32'd7, 1'b0, 1'b0), 32'd14);
        chk("model_remu", ref_result(32'd100, 32'd7, 1'b0, 1'b1), 32'd2);
        chk("model_div_neg", ref_result(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0), 32'hFFFF_FFFD);
        chk("model_rem_neg", ref_result(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1), 32'hFFFF_FFFF);
        chk("model_ovf_q", ref_result(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0), 32'h8000_0000);
        chk("model_ovf_r", ref_result(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1), 32'd0);

        // Directed cases with literal expectations.
        do_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 2, 0);
        do_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 0, 1);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 3, 0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 0, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 2, 0);
        do_op(32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1, 0);
        do_op(32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 0, 0);
        do_op(32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 2, 3);
        do_op(32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 1, 3);

        // Flush while waiting on the divider, then a stray done in IDLE.
        start_req(32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
        cyc();
        chk("fl_wait_pre", {31'd0, div_valid}, 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_wait_dv", {31'd0, div_valid}, 32'd0);
        chk("fl_wait_rv", {31'd0, rsp_valid}, 32'd0);
        chk("fl_wait_rr", {31'd0, req_ready}, 32'd1);
        div_done = 1'b1;
        cyc();
        div_done = 1'b0;
        chk("stray_done_rv", {31'd0, rsp_valid}, 32'd0);
        chk("stray_done_dv", {31'd0, div_valid}, 32'd0);

        // Flush together with div_done.
        start_req(32'd50, 32'd5, 1'b0, 1'b0, 32'd10);
        flush = 1'b1;
        give_done(32'd50, 32'd5, 1'b0);
        flush = 1'b0;
        chk("fl_done_rv", {31'd0, rsp_valid}, 32'd0);
        chk("fl_done_rr", {31'd0, req_ready}, 32'd1);

        // Flush in RESP, including against a simultaneous handshake.
        start_req(32'd50, 32'd5, 1'b0, 1'b1, 32'd0);
        give_done(32'd50, 32'd5, 1'b0);
        chk("fl_resp_pre", {31'd0, rsp_valid}, 32'd1);
        flush = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        flush = 1'b0;
        rsp_ready = 1'b0;
        chk("fl_resp_rv", {31'd0, rsp_valid}, 32'd0);
        chk("fl_resp_rr", {31'd0, req_ready}, 32'd1);

        // Flush against an accept in IDLE.
        req_rs1 = 32'd8; req_rs2 = 32'd2; req_valid = 1'b1; flush = 1'b1;
        cyc();
        req_valid = 1'b0; flush = 1'b0;
        chk("fl_accept_dv", {31'd0, div_valid}, 32'd0);
        chk("fl_accept_rr", {31'd0, req_ready}, 32'd1);

        // Asynchronous reset in the middle of RESP.
        start_req(32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
        give_done(32'd100, 32'd7, 1'b0);
        chk("rst_mid_pre", {31'd0, rsp_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_rv", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_data", rsp_data, 32'd0);
        chk("rst_mid_rr", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_rs1", div_rs1, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            a = pick_operand();
            b = pick_operand();
            s = 1'($urandom);
            r = 1'($urandom);
            do_op(a, b, s, r, ref_result(a, b, s, r),
                  $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
